// File: rtl/done_pending.sv
// done_pending: pending-request stage in front of the interrupt controller.
// Captures rising edges on four accelerator done lines as pending requests
// and presents them one at a time, lowest index first, on done_out. Each
// request is retired by a rising edge on iack. A hold-off of HOLDOFF cycles
// follows every acknowledge before the next request is presented.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous reset, active low
//   done_in  - raw accelerator done levels (bit 0 = accelerator 1)
//   mask     - per-source enable for new events
//   iack     - CPU acknowledge level
//   ovf_clr  - clears all overrun bits
//   done_out - one-hot presented request (or zero)
//   sel_idx  - index of the presented source
//   pending  - latched, not-yet-acknowledged requests
//   overrun  - sticky: event arrived on an already-pending source
//   busy     - state is not IDLE
module done_pending #(
    parameter int HOLDOFF = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] done_in,
    input  logic [3:0] mask,
    input  logic       iack,
    input  logic       ovf_clr,
    output logic [3:0] done_out,
    output logic [1:0] sel_idx,
    output logic [3:0] pending,
    output logic [3:0] overrun,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] done_q;
    logic       iack_q;
    logic [3:0] pending_q, pending_d;
    logic [3:0] overrun_q, overrun_d;
    logic [3:0] sel_q, sel_d;
    logic [7:0] cnt_q, cnt_d;

    logic [3:0] ev;
    logic       ack;
    logic [3:0] clr;

    assign ev  = done_in & ~done_q & mask;
    assign ack = iack & ~iack_q;
    // Only an acknowledge while presenting retires anything.
    assign clr = (state_q == PRESENT && ack) ? sel_q : 4'b0000;

    always_comb begin
        // Set wins over clear on the same source.
        pending_d = (pending_q & ~clr) | ev;
        // A new overrun wins over ovf_clr; an event coinciding with the
        // retirement of the same source is a fresh request, not an overrun.
        overrun_d = (ovf_clr ? 4'b0000 : overrun_q) | (ev & pending_q & ~clr);
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pending_q != 4'b0000) begin
                    // Isolate the lowest set bit.
                    sel_d   = pending_q & (~pending_q + 4'd1);
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) begin
                    cnt_d   = 8'(HOLDOFF);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            done_q    <= 4'b0000;
            iack_q    <= 1'b0;
            pending_q <= 4'b0000;
            overrun_q <= 4'b0000;
            sel_q     <= 4'b0000;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_in;
            iack_q    <= iack;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
        end
    end

    // Outputs come straight from registers; no combinational input paths.
    assign done_out = (state_q == PRESENT) ? sel_q : 4'b0000;
    assign pending  = pending_q;
    assign overrun  = overrun_q;
    assign busy     = (state_q != IDLE);

    always_comb begin
        sel_idx = 2'd0;
        unique case (sel_q)
            4'b0010: sel_idx = 2'd1;
            4'b0100: sel_idx = 2'd2;
            4'b1000: sel_idx = 2'd3;
            default: sel_idx = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_done_pending.sv
module tb_done_pending;

    logic       clk;
    logic       rst;
    logic [3:0] done_in;
    logic [3:0] mask;
    logic       iack;
    logic       ovf_clr;
    logic [3:0] done_out;
    logic [1:0] sel_idx;
    logic [3:0] pending;
    logic [3:0] overrun;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    done_pending #(.HOLDOFF(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .done_in  (done_in),
        .mask     (mask),
        .iack     (iack),
        .ovf_clr  (ovf_clr),
        .done_out (done_out),
        .sel_idx  (sel_idx),
        .pending  (pending),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        done_in = 4'b0000;
        iack    = 1'b0;
        ovf_clr = 1'b0;
        mask    = 4'b1111;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        // ---- reset values ----
        rst     = 1'b0;
        done_in = 4'b1111;
        mask    = 4'b1111;
        iack    = 1'b0;
        ovf_clr = 1'b0;
        #2;
        chk("rst_done_out", 8'(done_out), 8'h0);
        chk("rst_sel_idx",  8'(sel_idx),  8'h0);
        chk("rst_pending",  8'(pending),  8'h0);
        chk("rst_overrun",  8'(overrun),  8'h0);
        chk("rst_busy",     8'(busy),     8'h0);
        step();
        step();
        chk("rst_hold_pending", 8'(pending), 8'h0);
        rst = 1'b1;
        step();
        chk("rel_pending",  8'(pending),  8'hf);
        chk("rel_done_out0", 8'(done_out), 8'h0);
        step();
        chk("rel_done_out", 8'(done_out), 8'h1);
        chk("rel_sel_idx",  8'(sel_idx),  8'h0);
        chk("rel_busy",     8'(busy),     8'h1);

        // ---- priority and hold-off sequencing ----
        do_reset();
        done_in = 4'b1010;
        step();
        chk("pri_pending", 8'(pending), 8'ha);
        done_in = 4'b0000;
        step();
        chk("pri_done_out", 8'(done_out), 8'h2);
        chk("pri_sel_idx",  8'(sel_idx),  8'h1);
        iack = 1'b1;
        step();
        iack = 1'b0;
        chk("ack_done_out0", 8'(done_out), 8'h0);
        chk("ack_pending",   8'(pending),  8'h8);
        chk("ack_busy",      8'(busy),     8'h1);
        step();
        chk("hold_done_out1", 8'(done_out), 8'h0);
        step();
        chk("hold_done_out2", 8'(done_out), 8'h0);
        chk("hold_idle_busy", 8'(busy),     8'h0);
        step();
        chk("next_done_out", 8'(done_out), 8'h8);
        chk("next_sel_idx",  8'(sel_idx),  8'h3);

        // ---- overrun ----
        do_reset();
        done_in = 4'b0001;
        step();
        chk("ovr_pending", 8'(pending), 8'h1);
        done_in = 4'b0000;
        step();
        done_in = 4'b0001;
        step();
        chk("ovr_set", 8'(overrun), 8'h1);
        done_in = 4'b0000;
        ovf_clr = 1'b1;
        step();
        chk("ovr_clr", 8'(overrun), 8'h0);
        done_in = 4'b0001;
        step();
        chk("ovr_set_vs_clr", 8'(overrun), 8'h1);
        ovf_clr = 1'b0;
        done_in = 4'b0000;

        // ---- mask ----
        do_reset();
        mask    = 4'b1110;
        done_in = 4'b0001;
        step();
        chk("mask_pending", 8'(pending), 8'h0);
        step();
        chk("mask_busy", 8'(busy), 8'h0);
        done_in = 4'b0100;
        step();
        chk("mask2_pending", 8'(pending), 8'h4);
        done_in = 4'b0000;
        mask    = 4'b1010;
        step();
        chk("mask2_done_out", 8'(done_out), 8'h4);
        chk("mask2_sel_idx",  8'(sel_idx),  8'h2);
        step();
        chk("mask2_still", 8'(done_out), 8'h4);

        // ---- acknowledge edge cases ----
        do_reset();
        done_in = 4'b0011;
        step();
        done_in = 4'b0000;
        step();
        chk("ackh_done_out", 8'(done_out), 8'h1);
        iack = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("ackh_pending",  8'(pending),  8'h2);
        chk("ackh_done_out2", 8'(done_out), 8'h2);
        iack = 1'b0;
        step();
        iack = 1'b1;
        step();
        iack = 1'b0;
        chk("ackh_retire", 8'(pending), 8'h0);
        step();
        step();
        step();
        chk("idle_busy", 8'(busy), 8'h0);
        iack = 1'b1;
        step();
        chk("idle_ack_busy",    8'(busy),     8'h0);
        chk("idle_ack_done_out", 8'(done_out), 8'h0);
        iack = 1'b0;
        step();
        done_in = 4'b0100;
        step();
        done_in = 4'b0000;
        step();
        chk("coin_present", 8'(done_out), 8'h4);
        done_in = 4'b0100;
        iack    = 1'b1;
        step();
        done_in = 4'b0000;
        iack    = 1'b0;
        chk("coin_pending",  8'(pending),  8'h4);
        chk("coin_overrun",  8'(overrun),  8'h0);
        chk("coin_done_out", 8'(done_out), 8'h0);
        step();
        step();
        chk("coin_gap", 8'(done_out), 8'h0);
        step();
        chk("coin_represent", 8'(done_out), 8'h4);

        // ---- asynchronous reset mid-PRESENT ----
        #3;
        rst = 1'b0;
        #1;
        chk("arst_done_out", 8'(done_out), 8'h0);
        chk("arst_pending",  8'(pending),  8'h0);
        chk("arst_busy",     8'(busy),     8'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
